// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the two-requester adder arbiter.
package adder_arb_pkg;

  localparam int ADD_W = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/adder_arbiter_ripple_carry_adder.sv
// Shared ripple-carry adder: one bit cell per position, with the carry chained
// from LSB to MSB.
module ripple_carry_adder
  import adder_arb_pkg::*;
#(
  parameter int W = ADD_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    // full-adder cell for bit i
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one ripple-carry adder between two
// valid/ready requesters. The result is registered and tagged with the
// owning requester.
// Optional: define ADDER_ARB_STATS_EN to add saturating per-requester grant
// counters (grant_cnt0/grant_cnt1, STAT_W bits wide).
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int STAT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADD_W-1:0]  req0_a,
  input  logic [ADD_W-1:0]  req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADD_W-1:0]  req1_a,
  input  logic [ADD_W-1:0]  req1_b,
  output logic              req1_ready,
  output logic              res_valid,
  output logic [ADD_W-1:0]  res_sum,
  output logic              res_cout,
  output logic              res_id,
`ifdef ADDER_ARB_STATS_EN
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1,
`endif
  input  logic              res_ready
);

  if (STAT_W < 1) begin : g_stat_w_chk
    $error("STAT_W must be at least 1");
  end

  state_t             state, state_nxt;
  logic               last_grant;
  logic               win;
  logic               hs;
  logic [ADD_W-1:0]   op_a, op_b;
  logic               op_id;
  logic [ADD_W-1:0]   add_sum;
  logic               add_cout;

  // winner selection, grant handshake and next-state decode
  always_comb begin
    state_nxt  = state;
    hs         = 1'b0;
    win        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          hs         = 1'b1;
          req0_ready = (win == REQ0);
          req1_ready = (win == REQ1);
          state_nxt  = CALC;
        end
      end
      CALC:    state_nxt = RESULT;
      RESULT:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // operand capture and round-robin pointer, updated only on a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= REQ0;
      last_grant <= REQ1;
    end else if (hs) begin
      op_a       <= (win == REQ1) ? req1_a : req0_a;
      op_b       <= (win == REQ1) ? req1_b : req0_b;
      op_id      <= win;
      last_grant <= win;
    end
  end

  ripple_carry_adder #(.W(ADD_W)) u_rca (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // result register: loaded at the end of CALC, released on consumer handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_id    <= REQ0;
    end else if (state == CALC) begin
      res_valid <= 1'b1;
      res_sum   <= add_sum;
      res_cout  <= add_cout;
      res_id    <= op_id;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef ADDER_ARB_STATS_EN
  // saturating grant counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (hs) begin
      if (win == REQ0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (win == REQ1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule
